// File: rtl/inst_encoder.sv
// Packs opcode, register/funct fields and a signed immediate into an RV32 word,
// validates the immediate, and streams accepted words into instruction memory.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    input  logic        restart,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] inst_count
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;

    localparam logic [1:0] EC_NONE  = 2'd0;
    localparam logic [1:0] EC_OPC   = 2'd1;
    localparam logic [1:0] EC_RANGE = 2'd2;
    localparam logic [1:0] EC_ALIGN = 2'd3;

    typedef enum logic [1:0] {IDLE, ENC, WRITE, ERR} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [6:0]         r_opcode;
    logic [6:0]         r_funct7;
    logic [4:0]         r_rd;
    logic [4:0]         r_rs1;
    logic [4:0]         r_rs2;
    logic [2:0]         r_funct3;
    logic signed [31:0] r_imm;
    logic [31:0]        w_word;
    logic [1:0]         w_code;
    logic               w_fit12;
    logic               w_fit13;
    logic               w_fit21;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (in_valid && !restart) w_next = ENC;
            ENC:   w_next = (w_code == EC_NONE) ? WRITE : ERR;
            WRITE: if (mem_ready) w_next = IDLE;
            ERR:   w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == IDLE) && !restart;
        mem_we   = (r_state == WRITE);
        err      = (r_state == ERR);
    end

    // Field capture is data only; it is qualified by the handshake, not reset.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && in_valid && !restart) begin
            r_opcode <= opcode;
            r_funct7 <= funct7;
            r_rd     <= rd;
            r_rs1    <= rs1;
            r_rs2    <= rs2;
            r_funct3 <= funct3;
            r_imm    <= imm;
        end
    end

    // An immediate fits N signed bits when everything above bit N-2 is a sign copy.
    assign w_fit12 = (&r_imm[31:11]) || !(|r_imm[31:11]);
    assign w_fit13 = (&r_imm[31:12]) || !(|r_imm[31:12]);
    assign w_fit21 = (&r_imm[31:20]) || !(|r_imm[31:20]);

    always_comb begin
        w_word = 32'd0;
        w_code = EC_NONE;
        case (r_opcode)
            OP_R: w_word = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode};
            OP_ADDI, OP_LW: begin
                w_word = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
                if (!w_fit12) w_code = EC_RANGE;
            end
            OP_S: begin
                w_word = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode};
                if (!w_fit12) w_code = EC_RANGE;
            end
            OP_B: begin
                w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                          r_imm[4:1], r_imm[11], r_opcode};
                if (r_imm[0])      w_code = EC_ALIGN;
                else if (!w_fit13) w_code = EC_RANGE;
            end
            OP_J: begin
                w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode};
                if (r_imm[0])      w_code = EC_ALIGN;
                else if (!w_fit21) w_code = EC_RANGE;
            end
            default: w_code = EC_OPC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'd0;
            err_code   <= EC_NONE;
            inst_count <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (restart) begin
                        mem_addr   <= BASE_ADDR;
                        inst_count <= 16'd0;
                    end
                end
                ENC: begin
                    err_code <= w_code;
                    if (w_code == EC_NONE) mem_wdata <= w_word;
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_addr   <= mem_addr + ADDR_STEP;
                        inst_count <= sat_inc(inst_count);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vector table, hand-built
// restart/reset sequences, and randomized bundles against a decode-based model.
module tb_inst_encoder;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] STEP = 32'd4;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = 7'd0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        restart = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] inst_count;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_addr  = BASE;
    logic [15:0] exp_count = 16'd0;
    logic [1:0]  last_code = 2'd0;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        int          stall;
        logic [1:0]  code;
        logic [31:0] word;
    } vec_t;

    vec_t vt[11];

    inst_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .restart(restart), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .err(err), .err_code(err_code), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ID-stage immediate generator: the reference inverse of the encoder.
    function automatic logic [31:0] id_imm(input logic [31:0] w);
        case (w[6:0])
            OP_ADDI, OP_LW: return {{20{w[31]}}, w[31:20]};
            OP_S:           return {{20{w[31]}}, w[31:25], w[11:7]};
            OP_B:           return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            OP_J:           return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:        return 32'd0;
        endcase
    endfunction

    // Expected error code from plain signed-range arithmetic.
    function automatic logic [1:0] model_err(input logic [6:0] op, input logic [31:0] im);
        int s;
        s = $signed(im);
        case (op)
            OP_R: return 2'd0;
            OP_ADDI, OP_LW, OP_S: return (s < -2048 || s > 2047) ? 2'd2 : 2'd0;
            OP_B: begin
                if (im[0]) return 2'd3;
                return (s < -4096 || s > 4095) ? 2'd2 : 2'd0;
            end
            OP_J: begin
                if (im[0]) return 2'd3;
                return (s < -(1 << 20) || s > (1 << 20) - 1) ? 2'd2 : 2'd0;
            end
            default: return 2'd1;
        endcase
    endfunction

    task automatic check_fields(input logic [31:0] w, input vec_t v);
        chk("dec_opcode", 32'(w[6:0]), 32'(v.op));
        case (v.op)
            OP_R: begin
                chk("dec_rd", 32'(w[11:7]), 32'(v.rd));
                chk("dec_f3", 32'(w[14:12]), 32'(v.f3));
                chk("dec_rs1", 32'(w[19:15]), 32'(v.rs1));
                chk("dec_rs2", 32'(w[24:20]), 32'(v.rs2));
                chk("dec_f7", 32'(w[31:25]), 32'(v.f7));
            end
            OP_ADDI, OP_LW: begin
                chk("dec_rd", 32'(w[11:7]), 32'(v.rd));
                chk("dec_f3", 32'(w[14:12]), 32'(v.f3));
                chk("dec_rs1", 32'(w[19:15]), 32'(v.rs1));
                chk("dec_imm", id_imm(w), v.imm);
            end
            OP_S, OP_B: begin
                chk("dec_f3", 32'(w[14:12]), 32'(v.f3));
                chk("dec_rs1", 32'(w[19:15]), 32'(v.rs1));
                chk("dec_rs2", 32'(w[24:20]), 32'(v.rs2));
                chk("dec_imm", id_imm(w), v.imm);
            end
            OP_J: begin
                chk("dec_rd", 32'(w[11:7]), 32'(v.rd));
                chk("dec_imm", id_imm(w), v.imm);
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input vec_t v, input logic chk_word);
        logic [31:0] w;
        @(negedge clk);
        opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm; in_valid = 1'b1;
        #1 chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("enc_no_we", 32'(mem_we), 32'd0);
        chk("enc_no_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        if (v.code != 2'd0) begin
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_code", 32'(err_code), 32'(v.code));
            chk("err_no_we", 32'(mem_we), 32'd0);
            @(posedge clk); #1;
            chk("err_one_cycle", 32'(err), 32'd0);
            chk("err_code_held", 32'(err_code), 32'(v.code));
            chk("err_no_we2", 32'(mem_we), 32'd0);
            chk("err_addr_hold", mem_addr, exp_addr);
            chk("err_count_hold", 32'(inst_count), 32'(exp_count));
            chk("err_back_idle", 32'(in_ready), 32'd1);
        end else begin
            chk("we_latency", 32'(mem_we), 32'd1);
            chk("we_addr", mem_addr, exp_addr);
            chk("ok_err_code", 32'(err_code), 32'd0);
            chk("write_busy", 32'(in_ready), 32'd0);
            w = mem_wdata;
            if (chk_word) chk("wdata", w, v.word);
            check_fields(w, v);
            for (int i = 0; i < v.stall; i++) begin
                restart = 1'b1;
                @(posedge clk); #1;
                chk("stall_we", 32'(mem_we), 32'd1);
                chk("stall_addr", mem_addr, exp_addr);
                chk("stall_wdata", mem_wdata, w);
                chk("stall_busy", 32'(in_ready), 32'd0);
            end
            restart = 1'b0;
            mem_ready = 1'b1;
            @(posedge clk); #1;
            mem_ready = 1'b0;
            exp_addr = exp_addr + STEP;
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            chk("we_drop", 32'(mem_we), 32'd0);
            chk("addr_step", mem_addr, exp_addr);
            chk("count_inc", 32'(inst_count), 32'(exp_count));
            chk("ready_again", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1; in_valid = 1'b1; opcode = OP_R;
        #1 chk("restart_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        restart = 1'b0; in_valid = 1'b0;
        exp_addr = BASE; exp_count = 16'd0;
        chk("restart_addr", mem_addr, exp_addr);
        chk("restart_count", 32'(inst_count), 32'(exp_count));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("restart_no_accept", {30'd0, mem_we, err}, 32'd0);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, BASE);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_count"}, 32'(inst_count), 32'd0);
    endtask

    initial begin
        vec_t        rv;
        logic [6:0]  ops [6];
        int          s;
        int          k;

        ops[0] = OP_R; ops[1] = OP_ADDI; ops[2] = OP_LW;
        ops[3] = OP_S; ops[4] = OP_B;    ops[5] = OP_J;

        vt[0]  = '{OP_R,    5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0001_2345, 0, 2'd0, 32'h002081B3};
        vt[1]  = '{OP_ADDI, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 0, 2'd0, 32'hFFF10093};
        vt[2]  = '{OP_S,    5'd7, 5'd2, 5'd5, 3'd2, 7'd0, 32'h0000_0008, 0, 2'd0, 32'h00512423};
        vt[3]  = '{OP_B,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 3, 2'd0, 32'hFE000EE3};
        vt[4]  = '{OP_J,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 0, 2'd0, 32'h001000EF};
        vt[5]  = '{OP_LW,   5'd4, 5'd9, 5'd0, 3'd2, 7'd0, 32'hFFFF_F800, 1, 2'd0, 32'h8004A203};
        vt[6]  = '{OP_ADDI, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 0, 2'd2, 32'h0};
        vt[7]  = '{OP_B,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0003, 0, 2'd3, 32'h0};
        vt[8]  = '{7'd0,    5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0000_0000, 0, 2'd1, 32'h0};
        vt[9]  = '{OP_B,    5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'h0000_1000, 0, 2'd2, 32'h0};
        vt[10] = '{OP_J,    5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0001, 0, 2'd3, 32'h0};

        #12;
        chk_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_op(vt[i], 1'b1);

        do_restart();
        run_op(vt[1], 1'b1);
        run_op(vt[2], 1'b1);
        chk("two_writes_addr", mem_addr, BASE + 2 * STEP);
        do_restart();

        for (int n = 0; n < 150; n++) begin
            rv.op  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            rv.rd  = 5'($urandom); rv.rs1 = 5'($urandom); rv.rs2 = 5'($urandom);
            rv.f3  = 3'($urandom); rv.f7  = 7'($urandom);
            k = $urandom_range(0, 2);
            if (k == 0) begin
                rv.imm = $urandom;
            end else if (k == 1) begin
                k = $urandom_range(0, 2);
                s = (k == 0) ? 2048 : (k == 1) ? 4096 : (1 << 20);
                if ($urandom_range(0, 1) == 1) s = -s;
                k = $urandom_range(0, 4);
                s = s + k - 2;
                rv.imm = s;
            end else begin
                k = $urandom_range(0, 600);
                s = k - 300;
                rv.imm = s;
            end
            if ((rv.op == OP_B || rv.op == OP_J) && $urandom_range(0, 1) == 1) rv.imm[0] = 1'b0;
            rv.stall = $urandom_range(0, 2);
            rv.code  = model_err(rv.op, rv.imm);
            rv.word  = 32'd0;
            run_op(rv, 1'b0);
        end

        // Asynchronous reset in the middle of a stalled write.
        @(negedge clk);
        opcode = OP_ADDI; rd = 5'd1; rs1 = 5'd2; imm = 32'd5; funct3 = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_we", 32'(mem_we), 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_state("rst_write");
        @(negedge clk);
        rst = 1'b0;
        exp_addr = BASE; exp_count = 16'd0;
        @(posedge clk); #1;
        chk("rst_word_lost", 32'(mem_we), 32'd0);
        run_op(vt[0], 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
